crc8_serial_check: RTL

CRC8_SERIAL_CHECK -- requirements
Module: crc8_serial_check

---
 rtl/crc8_serial_check.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/crc8_serial_check.sv
// Serial CRC-8 (poly 0x39, init 0xFF) frame checker with one-byte holdback.
// Optional errcnt output enabled by CRC8_SERIAL_CHECK_ERRCNT_EN.
module crc8_serial_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        en,
  input  logic        frame,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        done,
  output logic        crc_ok,
  output logic        err_align,
  output logic        err_short,
  output logic [7:0]  len
`ifdef CRC8_SERIAL_CHECK_ERRCNT_EN
  ,
  output logic [15:0] errcnt
`endif
);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t     state;
  logic [7:0] r;
  logic [7:0] asm_q;
  logic [7:0] held;
  logic [2:0] cnt;
  logic       hflag;
  logic [7:0] lcnt;

  logic [7:0] nxt_byte;
  logic [7:0] r_fold;
  logic [7:0] chk;
  logic       end_align;
  logic       end_short;
  logic       end_ok;

  function automatic logic [7:0] fold8(
    input logic [7:0] rin,
    input logic [7:0] b
  );
    logic [7:0] rv;
    logic       d;
    rv = rin;
    for (int i = 7; i >= 0; i--) begin
      d  = b[i] ^ rv[7];
      rv = {rv[6:0], 1'b0} ^ (d ? 8'h39 : 8'h00);
    end
    return rv;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[7-i] = v[i];
    return o;
  endfunction

  // The last complete byte stays held back: it is the CRC byte
  // unless another byte completes after it.
  always_comb begin
    nxt_byte  = {asm_q[6:0], din};
    r_fold    = fold8(r, held);
    chk       = rev8(r);
    end_align = (cnt != 3'd0);
    end_short = !hflag;
    end_ok    = !end_align && !end_short && (held == chk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= 8'hFF;
      asm_q      <= 8'h00;
      held       <= 8'h00;
      cnt        <= 3'd0;
      hflag      <= 1'b0;
      lcnt       <= 8'd0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      err_align  <= 1'b0;
      err_short  <= 1'b0;
      len        <= 8'd0;
`ifdef CRC8_SERIAL_CHECK_ERRCNT_EN
      errcnt     <= 16'd0;
`endif
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame) begin
            state <= RECV;
            r     <= 8'hFF;
            hflag <= 1'b0;
            lcnt  <= 8'd0;
            if (en) begin
              asm_q <= nxt_byte;
              cnt   <= 3'd1;
            end else begin
              cnt   <= 3'd0;
            end
          end
        end
        RECV: begin
          if (!frame) begin
            state     <= IDLE;
            done      <= 1'b1;
            crc_ok    <= end_ok;
            err_align <= end_align;
            err_short <= end_short;
            len       <= lcnt;
`ifdef CRC8_SERIAL_CHECK_ERRCNT_EN
            if (!end_ok && errcnt != 16'hFFFF)
              errcnt <= errcnt + 16'd1;
`endif
          end else if (en) begin
            asm_q <= nxt_byte;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              held <= nxt_byte;
              if (!hflag) begin
                hflag <= 1'b1;
              end else begin
                r          <= r_fold;
                data       <= held;
                data_valid <= 1'b1;
                if (lcnt != 8'hFF)
                  lcnt <= lcnt + 8'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
